// File: rtl/mdu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// mdu_seq_ctrl_if
// Request/response bundle between the EX stage and the multiply/divide
// sequencer. The pipeline side is the master, the sequencer is the slave.
// Revision: 1.0
// ============================================================================
interface mdu_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             kill;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             stall;

  modport master (
    output start, kill, funct3, a, b,
    input  result, done, busy, stall
  );

  modport slave (
    input  start, kill, funct3, a, b,
    output result, done, busy, stall
  );
endinterface
`default_nettype wire

// File: rtl/mdu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// mdu_seq_ctrl
// Iterative RV32M multiply/divide sequencer: shift-add multiply and
// restoring divide over magnitudes, with sign fix-up at the end and a short
// path for divide-by-zero and signed overflow.
// Revision: 1.0
// ============================================================================
module mdu_seq_ctrl #(
  parameter int WIDTH        = 32,
  parameter int CNT_W        = 6,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mdu_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [2:0]         op;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               special;
  logic [WIDTH-1:0]   special_res;
  logic [WIDTH-1:0]   result;

  logic done_c, busy_c, stall_c;

  // ---------------------------------------------------------------------------
  // Operand classification and magnitudes (from the latched request)
  // ---------------------------------------------------------------------------
  logic             is_div, a_signed, b_signed, a_neg, b_neg;
  logic             div_zero, div_ovf, special_now;
  logic [WIDTH-1:0] mag_a, mag_b, special_val, first_opnd;
  logic [WIDTH-1:0] int_min;

  assign int_min     = {1'b1, {(WIDTH-1){1'b0}}};
  assign is_div      = op[2];
  assign a_signed    = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
  assign b_signed    = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
  assign a_neg       = a_signed & op_a[WIDTH-1];
  assign b_neg       = b_signed & op_b[WIDTH-1];
  assign mag_a       = a_neg ? -op_a : op_a;
  assign mag_b       = b_neg ? -op_b : op_b;
  assign div_zero    = (op_b == '0);
  assign div_ovf     = ((op == 3'b100) | (op == 3'b110)) & (op_a == int_min) & (op_b == '1);
  assign special_now = is_div & (div_zero | div_ovf);
  // REM/REMU carry op[1]=1: remainder gets the dividend (zero) or 0 (overflow)
  assign special_val = op[1] ? (div_zero ? op_a : '0) : (div_zero ? '1 : int_min);
  // Multiply: multiplicand mag_a, multiplier in the low half. Divide: divisor mag_b.
  assign first_opnd  = is_div ? mag_b : mag_a;

  // ---------------------------------------------------------------------------
  // One iteration. PREP performs the first step directly on the freshly
  // formed magnitudes so CALC only needs WIDTH-1 further cycles.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] init_acc, src_acc, step_acc;
  logic [WIDTH-1:0]   src_opnd;
  logic [WIDTH:0]     add_sum, rem_sh, rem_diff;

  assign init_acc = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
  assign src_acc  = (state == S_PREP) ? init_acc : acc;
  assign src_opnd = (state == S_PREP) ? first_opnd : opnd;
  assign add_sum  = {1'b0, src_acc[2*WIDTH-1:WIDTH]} + {1'b0, src_opnd};
  assign rem_sh   = src_acc[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, src_opnd};

  // Shift-add multiply step or restoring divide step
  always_comb begin
    step_acc = src_acc;
    if (is_div) begin
      if (!rem_diff[WIDTH]) begin
        step_acc = {rem_diff[WIDTH-1:0], src_acc[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = {rem_sh[WIDTH-1:0], src_acc[WIDTH-2:0], 1'b0};
      end
    end else if (src_acc[0]) begin
      step_acc = {add_sum, src_acc[WIDTH-1:1]};
    end else begin
      step_acc = {1'b0, src_acc[2*WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Sign correction and output selection
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, fix_val;

  assign prod = (sign_a ^ sign_b) ? -acc : acc;
  assign quot = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // Result word for the latched op; special cases override the iteration
  always_comb begin
    fix_val = prod[WIDTH-1:0];
    case (op)
      3'b000:                 fix_val = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_val = quot;
      default:                fix_val = rem;
    endcase
    if (special) begin
      fix_val = special_res;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    done_c    = 1'b0;
    busy_c    = (state != S_IDLE);
    stall_c   = (bus.start & (state == S_IDLE)) | ((state != S_IDLE) & (state != S_DONE));
    case (state)
      S_IDLE: if (bus.start && !bus.kill) state_nxt = S_PREP;
      S_PREP: begin
        if (bus.kill)                         state_nxt = S_IDLE;
        else if (FAST_SPECIAL && special_now) state_nxt = S_DONE;
        else                                  state_nxt = S_CALC;
      end
      S_CALC: begin
        if (bus.kill)                          state_nxt = S_IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))     state_nxt = S_FIX;
      end
      S_FIX:  state_nxt = bus.kill ? S_IDLE : S_DONE;
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers; a kill leaves everything (notably result) untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op          <= '0;
      op_a        <= '0;
      op_b        <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      cnt         <= '0;
      special     <= 1'b0;
      special_res <= '0;
      result      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.kill) begin
            op   <= bus.funct3;
            op_a <= bus.a;
            op_b <= bus.b;
          end
        end
        S_PREP: begin
          if (!bus.kill) begin
            sign_a      <= a_neg;
            sign_b      <= b_neg;
            opnd        <= first_opnd;
            acc         <= step_acc;
            cnt         <= CNT_W'(1);
            special     <= special_now;
            special_res <= special_val;
            if (FAST_SPECIAL && special_now) begin
              result <= special_val;
            end
          end
        end
        S_CALC: begin
          if (!bus.kill) begin
            acc <= step_acc;
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!bus.kill) begin
            result <= fix_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result;
  assign bus.done   = done_c;
  assign bus.busy   = busy_c;
  assign bus.stall  = stall_c;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mdu_seq_ctrl
// Directed vector table, hand-written kill/reset sequences and random ops
// compared against an arithmetic reference model.
// Revision: 1.0
// ============================================================================
module tb_mdu_seq_ctrl;

  localparam int NORM_LAT  = 33;  // edges from the sampling edge to DONE
  localparam int SHORT_LAT = 1;
  localparam int NRAND     = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mdu_seq_ctrl_if bus ();

  mdu_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural RV32M result from plain integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    p  = '0;
    case (f3)
      3'd0: begin p = ua * ub;           return p[31:0];  end
      3'd1: begin p = sa * sb;           return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;           return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op in an IDLE cycle, measure latency and stall, check result,
  // then step into the following IDLE cycle.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int edges;
    int stall_cnt;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    edges     = 0;
    stall_cnt = 0;
    while (!bus.done && edges < 100) begin
      if (bus.stall) stall_cnt++;
      @(posedge clk);
      #1;
      edges++;
    end
    check({name, " latency"}, 32'(edges), 32'(lat));
    check({name, " result"}, bus.result, exp);
    check({name, " stall cycles"}, 32'(stall_cnt), 32'(lat));
    check({name, " stall/busy in DONE"}, {30'd0, bus.stall, bus.busy}, 32'd1);
    @(posedge clk);
    #1;
    check({name, " idle after DONE"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev;
    int          dones;
    logic [2:0]  f3;
    logic [31:0] ra, rb;
    int          lat;

    tbl[0]  = '{"MUL 7*-3",         3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM_LAT};
    tbl[1]  = '{"MULH min*min",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, NORM_LAT};
    tbl[2]  = '{"MULHU max*max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, NORM_LAT};
    tbl[3]  = '{"MULHSU -1*2",      3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, NORM_LAT};
    tbl[4]  = '{"DIVU 100/7",       3'd5, 32'd100,        32'd7,         32'd14,        NORM_LAT};
    tbl[5]  = '{"REMU 100/7",       3'd7, 32'd100,        32'd7,         32'd2,         NORM_LAT};
    tbl[6]  = '{"DIV -7/2",         3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, NORM_LAT};
    tbl[7]  = '{"REM -7/2",         3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, NORM_LAT};
    tbl[8]  = '{"DIV 5/0",          3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, SHORT_LAT};
    tbl[9]  = '{"REM 5/0",          3'd6, 32'd5,          32'd0,         32'd5,         SHORT_LAT};
    tbl[10] = '{"DIV overflow",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, SHORT_LAT};
    tbl[11] = '{"REM overflow",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         SHORT_LAT};
    tbl[12] = '{"DIVU 5/0",         3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, SHORT_LAT};
    tbl[13] = '{"REMU 5/0",         3'd7, 32'd5,          32'd0,         32'd5,         SHORT_LAT};
    tbl[14] = '{"DIVU min/max",     3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         NORM_LAT};
    tbl[15] = '{"MUL min*-1",       3'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, NORM_LAT};

    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.funct3 = 3'd0;
    bus.a      = '0;
    bus.b      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {bus.result[0], bus.done, bus.busy, bus.stall, 28'd0}, 32'd0);
    check("reset result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, applied back-to-back
    foreach (tbl[i]) begin
      do_op(tbl[i].name, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);
    end

    // kill together with start in IDLE: request not taken
    @(negedge clk);
    bus.start = 1'b1;
    bus.kill  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    check("start+kill ignored", {31'd0, bus.busy}, 32'd0);

    // kill during CALC: back to IDLE, no done, result retained
    prev = bus.result;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd0;
    bus.a      = 32'd123;
    bus.b      = 32'd456;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    repeat (11) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    check("kill -> idle", {31'd0, bus.busy}, 32'd0);
    check("kill keeps result", bus.result, prev);
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("kill no done", 32'(dones), 32'd0);
    do_op("MUL after kill", 3'd0, 32'd123, 32'd456, 32'd56088, NORM_LAT);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd5;
    bus.a      = 32'd1000;
    bus.b      = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async reset busy/done/stall", {29'd0, bus.busy, bus.done, bus.stall}, 32'd0);
    check("async reset result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("DIVU after reset", 3'd5, 32'd1000, 32'd3, 32'd333, NORM_LAT);

    // Random ops against the reference model
    for (int i = 0; i < NRAND; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = 32'd0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      lat = (f3[2] && (rb == 0 || (!f3[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)))
            ? SHORT_LAT : NORM_LAT;
      do_op($sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, ra, rb), f3, ra, rb,
            model(f3, ra, rb), lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
